// File: rtl/dll_pkg.sv
// Shared widths, loop-order encoding and the saturating resize helper for
// the multi-channel DLL loop filter.
package dll_pkg;

  localparam int DLL_PW     = 29;
  localparam int DLL_CW     = 32;
  localparam int DLL_ACC_W  = 40;
  localparam int DLL_NCH    = 4;
  localparam int DLL_LOCK_N = 16;

  typedef enum logic {
    DLL_ORD1 = 1'b0,
    DLL_ORD2 = 1'b1
  } dll_order_e;

  // Clip a signed value into the range of a w-bit signed number (w <= 63).
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/dll_chan_state.sv
// Per-channel integrator and lock-counter storage: combinational read,
// one write port, and a clear port that overrides a same-channel write.
module dll_chan_state
  import dll_pkg::*;
#(
  parameter int NCH   = DLL_NCH,
  parameter int ACC_W = DLL_ACC_W,
  parameter int CNT_W = 5,
  parameter int CHW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHW-1:0]          rd_ch,
  output logic signed [ACC_W-1:0] rd_intg,
  output logic [CNT_W-1:0]        rd_cnt,
  input  logic                    wr_en,
  input  logic [CHW-1:0]          wr_ch,
  input  logic signed [ACC_W-1:0] wr_intg,
  input  logic [CNT_W-1:0]        wr_cnt,
  input  logic                    clr_en,
  input  logic [CHW-1:0]          clr_ch
);

  logic signed [ACC_W-1:0] intg [NCH];
  logic [CNT_W-1:0]        cnt  [NCH];

  assign rd_intg = intg[rd_ch];
  assign rd_cnt  = cnt[rd_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        intg[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_en && clr_ch == CHW'(i)) begin
          intg[i] <= '0;
          cnt[i]  <= '0;
        end else if (wr_en && wr_ch == CHW'(i)) begin
          intg[i] <= wr_intg;
          cnt[i]  <= wr_cnt;
        end
      end
    end
  end

endmodule

// File: rtl/dll_loop_filter.sv
// Multi-channel early-minus-late DLL loop filter: capture, discriminator stage,
// then a read-modify-write update stage that emits a tagged code correction.
module dll_loop_filter
  import dll_pkg::*;
#(
  parameter int PW     = DLL_PW,
  parameter int CW     = DLL_CW,
  parameter int ACC_W  = DLL_ACC_W,
  parameter int NCH    = DLL_NCH,
  parameter int LOCK_N = DLL_LOCK_N,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CNT_W = $clog2(LOCK_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CHW-1:0]       in_ch,
  input  logic [PW-1:0]        p_e,
  input  logic [PW-1:0]        p_l,
  input  logic                 order,
  input  logic [4:0]           k1_shift,
  input  logic [4:0]           k2_shift,
  input  logic [PW-1:0]        lock_thresh,
  input  logic                 clear_valid,
  input  logic [CHW-1:0]       clear_ch,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [CW-1:0] correction,
  output logic                 sat,
  output logic                 locked
);

  // Capture register: sample and its controls at acceptance.
  logic           v0;
  logic [CHW-1:0] ch0;
  logic [PW-1:0]  pe0, pl0, th0;
  dll_order_e     ord0;
  logic [4:0]     k10, k20;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0   <= 1'b0;
      ch0  <= '0;
      pe0  <= '0;
      pl0  <= '0;
      th0  <= '0;
      ord0 <= DLL_ORD1;
      k10  <= '0;
      k20  <= '0;
    end else begin
      v0 <= in_valid && (int'(in_ch) < NCH);
      if (in_valid) begin
        ch0  <= in_ch;
        pe0  <= p_e;
        pl0  <= p_l;
        th0  <= lock_thresh;
        ord0 <= dll_order_e'(order);
        k10  <= k1_shift;
        k20  <= k2_shift;
      end
    end
  end

  // Stage A: discriminator and lock-threshold test.
  logic signed [PW:0] disc_c;
  logic [PW:0]        mag_c;
  logic               va, thr_a;
  logic [CHW-1:0]     cha;
  logic signed [PW:0] disca;
  dll_order_e         orda;
  logic [4:0]         k1a, k2a;

  assign disc_c = $signed({1'b0, pe0}) - $signed({1'b0, pl0});
  assign mag_c  = disc_c[PW] ? -disc_c : disc_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va    <= 1'b0;
      thr_a <= 1'b0;
      cha   <= '0;
      disca <= '0;
      orda  <= DLL_ORD1;
      k1a   <= '0;
      k2a   <= '0;
    end else begin
      va <= v0;
      if (v0) begin
        thr_a <= mag_c <= {1'b0, th0};
        cha   <= ch0;
        disca <= disc_c;
        orda  <= ord0;
        k1a   <= k10;
        k2a   <= k20;
      end
    end
  end

  // Stage B: read channel state, update, register outputs.
  logic signed [ACC_W-1:0] rd_intg, intg_new, intg_use, wr_intg;
  logic [CNT_W-1:0]        rd_cnt, cnt_new;
  logic signed [PW:0]      prop, istep;
  logic signed [63:0]      isum, isum_sat, csum, csum_sat;
  logic                    clr_hit, ord2, isat, csat;

  assign clr_hit  = clear_valid && (clear_ch == cha);
  assign ord2     = (orda == DLL_ORD2);
  assign prop     = disca >>> k1a;
  assign istep    = disca >>> k2a;
  assign isum     = 64'(rd_intg) + 64'(istep);
  assign isum_sat = sat_s(isum, ACC_W);
  assign isat     = (isum_sat != isum);
  assign intg_new = isum_sat[ACC_W-1:0];
  // A colliding clear forces the integral term to zero for this result too.
  assign intg_use = (ord2 && !clr_hit) ? intg_new : '0;
  assign csum     = 64'(prop) + 64'(intg_use);
  assign csum_sat = sat_s(csum, CW);
  assign csat     = (csum_sat != csum);
  assign wr_intg  = ord2 ? intg_new : rd_intg;
  assign cnt_new  = thr_a ? ((rd_cnt == CNT_W'(LOCK_N)) ? rd_cnt : rd_cnt + 1'b1) : '0;

  dll_chan_state #(
    .NCH   (NCH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W),
    .CHW   (CHW)
  ) u_state (
    .clk     (clk),
    .rst     (rst),
    .rd_ch   (cha),
    .rd_intg (rd_intg),
    .rd_cnt  (rd_cnt),
    .wr_en   (va),
    .wr_ch   (cha),
    .wr_intg (wr_intg),
    .wr_cnt  (cnt_new),
    .clr_en  (clear_valid),
    .clr_ch  (clear_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      correction <= '0;
      sat        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      out_valid <= va;
      if (va) begin
        out_ch     <= cha;
        correction <= csum_sat[CW-1:0];
        sat        <= csat || (ord2 && !clr_hit && isat);
        locked     <= !clr_hit && (cnt_new == CNT_W'(LOCK_N));
      end
    end
  end

endmodule

// File: tb/tb_dll_loop_filter.sv
// Self-checking bench for dll_loop_filter: table vectors plus sequences,
// checked through an expected-result queue against a small integer model.
module tb_dll_loop_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [1:0]         in_ch;
  logic [28:0]        p_e, p_l, lock_thresh;
  logic               order;
  logic [4:0]         k1_shift, k2_shift;
  logic               clear_valid;
  logic [1:0]         clear_ch;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [31:0] correction;
  logic               sat, locked;

  always #5 clk = ~clk;

  dll_loop_filter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
    .p_e(p_e), .p_l(p_l), .order(order), .k1_shift(k1_shift), .k2_shift(k2_shift),
    .lock_thresh(lock_thresh), .clear_valid(clear_valid), .clear_ch(clear_ch),
    .out_valid(out_valid), .out_ch(out_ch), .correction(correction),
    .sat(sat), .locked(locked)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [28:0] pe, pl;
    logic        ord;
    logic [4:0]  k1, k2;
    logic [28:0] thr;
  } stim_t;

  typedef struct {
    logic [1:0]         ch;
    logic signed [31:0] corr;
    logic               sat;
    logic               lck;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  exp_t   sb[$];
  longint m_intg[4];
  int     m_cnt[4];
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Integer reference of one update; clr marks a same-channel clear collision.
  task automatic predict(input stim_t s, input bit clr, output exp_t e);
    longint disc, prop, istep, inew, c, iuse, mag;
    bit     isat, csat;
    int     cn;
    disc  = longint'(s.pe) - longint'(s.pl);
    prop  = disc >>> s.k1;
    istep = disc >>> s.k2;
    inew  = m_intg[s.ch] + istep;
    isat  = 1'b0;
    if (inew > 64'sd549755813887) begin inew = 64'sd549755813887; isat = 1'b1; end
    if (inew < -64'sd549755813888) begin inew = -64'sd549755813888; isat = 1'b1; end
    iuse = (s.ord && !clr) ? inew : 0;
    c    = prop + iuse;
    csat = 1'b0;
    if (c > 64'sd2147483647) begin c = 64'sd2147483647; csat = 1'b1; end
    if (c < -64'sd2147483648) begin c = -64'sd2147483648; csat = 1'b1; end
    mag = (disc < 0) ? -disc : disc;
    cn  = (mag <= longint'(s.thr)) ? ((m_cnt[s.ch] >= 16) ? 16 : m_cnt[s.ch] + 1) : 0;
    e.ch   = s.ch;
    e.corr = c[31:0];
    e.sat  = csat | (s.ord & ~clr & isat);
    e.lck  = !clr && (cn == 16);
    if (clr) begin
      m_intg[s.ch] = 0;
      m_cnt[s.ch]  = 0;
    end else begin
      if (s.ord) m_intg[s.ch] = inew;
      m_cnt[s.ch] = cn;
    end
  endtask

  task automatic send(input stim_t s, input bit clr, input bit use_tab, input exp_t te);
    exp_t e;
    predict(s, clr, e);
    if (use_tab) e = te;
    sb.push_back(e);
    in_valid = 1'b1; in_ch = s.ch; p_e = s.pe; p_l = s.pl; order = s.ord;
    k1_shift = s.k1; k2_shift = s.k2; lock_thresh = s.thr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_now(input logic [1:0] c);
    clear_valid = 1'b1; clear_ch = c;
    @(posedge clk); #1;
    clear_valid = 1'b0;
    m_intg[c] = 0;
    m_cnt[c]  = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out_valid actual=1 required=0 ch=%0d", out_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("correction", correction, e.corr);
        chk("sat", sat, e.sat);
        chk("locked", locked, e.lck);
      end
    end
  end

  vec_t  tab[7];
  stim_t s;
  exp_t  dummy;

  initial begin
    tab[0] = '{'{2'd0, 29'd1000, 29'd400, 1'b1, 5'd0, 5'd0, 29'd0}, '{2'd0, 32'sd1200, 1'b0, 1'b0}};
    tab[1] = '{'{2'd0, 29'd1000, 29'd400, 1'b1, 5'd0, 5'd0, 29'd0}, '{2'd0, 32'sd1800, 1'b0, 1'b0}};
    tab[2] = '{'{2'd0, 29'd100,  29'd501, 1'b0, 5'd2, 5'd0, 29'd0}, '{2'd0, -32'sd101, 1'b0, 1'b0}};
    tab[3] = '{'{2'd0, 29'd500,  29'd400, 1'b1, 5'd0, 5'd0, 29'd0}, '{2'd0, 32'sd1400, 1'b0, 1'b0}};
    tab[4] = '{'{2'd1, 29'd300,  29'd700, 1'b1, 5'd1, 5'd2, 29'd0}, '{2'd1, -32'sd300, 1'b0, 1'b0}};
    tab[5] = '{'{2'd1, 29'd7,    29'd0,   1'b1, 5'd3, 5'd3, 29'd0}, '{2'd1, -32'sd100, 1'b0, 1'b0}};
    tab[6] = '{'{2'd2, 29'd0,    29'd5,   1'b1, 5'd0, 5'd0, 29'd5}, '{2'd2, -32'sd10, 1'b0, 1'b0}};
    dummy = '{2'd0, 32'sd0, 1'b0, 1'b0};

    for (int c = 0; c < 4; c++) begin m_intg[c] = 0; m_cnt[c] = 0; end
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; p_e = '0; p_l = '0; order = 1'b0;
    k1_shift = '0; k2_shift = '0; lock_thresh = '0; clear_valid = 1'b0; clear_ch = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_ch", out_ch, 0);
    chk("reset_correction", correction, 0);
    chk("reset_sat", sat, 0);
    chk("reset_locked", locked, 0);

    // Table vectors, back-to-back.
    for (int i = 0; i < 7; i++) send(tab[i].s, 1'b0, 1'b1, tab[i].e);
    drain();

    // Saturation run on a freshly cleared ch1.
    clear_now(2'd1);
    s = '{2'd1, 29'h1FFF_FFFF, 29'd0, 1'b1, 5'd0, 5'd0, 29'd0};
    for (int i = 0; i < 5; i++) send(s, 1'b0, 1'b0, dummy);
    drain();

    // Lock on ch2: 16 in-threshold samples, then one outside.
    clear_now(2'd2);
    s = '{2'd2, 29'd105, 29'd100, 1'b0, 5'd0, 5'd0, 29'd10};
    for (int i = 0; i < 16; i++) send(s, 1'b0, 1'b0, dummy);
    s.pe = 29'd111;
    send(s, 1'b0, 1'b0, dummy);
    drain();

    // Interleaved channels; clear ch3 while its sample is in the update stage.
    for (int i = 0; i < 8; i++) begin
      s = '{2'(i % 4), 29'(1000 + 37 * i), 29'(900 - 11 * i), 1'b1, 5'd1, 5'd0, 29'd500};
      clear_valid = (i == 5); clear_ch = 2'd3;
      send(s, (i == 3), 1'b0, dummy);
      clear_valid = 1'b0;
    end
    drain();

    // Reset with two samples in flight.
    s = '{2'd0, 29'd2000, 29'd100, 1'b1, 5'd0, 5'd0, 29'd0};
    send(s, 1'b0, 1'b0, dummy);
    send(s, 1'b0, 1'b0, dummy);
    rst = 1'b1;
    sb.delete();
    for (int c = 0; c < 4; c++) begin m_intg[c] = 0; m_cnt[c] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_out_ch", out_ch, 0);
    chk("post_reset_correction", correction, 0);
    chk("post_reset_sat", sat, 0);
    chk("post_reset_locked", locked, 0);
    send(s, 1'b0, 1'b1, '{2'd0, 32'sd3800, 1'b0, 1'b0});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
